// File: rtl/dispensador_moedas.sv
// Dispensing actuator controller: runs the product motor, then pays change or a refund
// as timed ejector pulses, preferring 2-unit coins while the finite 2-unit tube lasts.
module dispensador_moedas #(
  parameter int MOTOR_CYCLES  = 50_000_000,
  parameter int PULSE_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int TUBO2_INICIAL = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       liberar,
  input  logic       devolver,
  input  logic [3:0] valor_moedas,
  input  logic [2:0] valor_produto,
  input  logic       recarga,
  output logic       motor_produto,
  output logic       ejetor2,
  output logic       ejetor1,
  output logic       ocupado,
  output logic       concluido,
  output logic [3:0] troco_restante,
  output logic       tubo2_vazio
);

  localparam int MAX_A = (MOTOR_CYCLES > PULSE_CYCLES) ? MOTOR_CYCLES : PULSE_CYCLES;
  localparam int MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] MOTOR_LOAD = CW'(MOTOR_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    TUBO2_INIT = 4'(TUBO2_INICIAL);

  typedef enum logic [2:0] {OCIOSO, MOTOR, ESCOLHE, EJETA, PAUSA, FIM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    troco_q, troco_d;
  logic [3:0]    tubo2_q, tubo2_d;
  logic          sel2_q, sel2_d;
  logic          lib_q, dev_q;
  logic          motor_q, motor_d;
  logic          ej2_q, ej2_d;
  logic          ej1_q, ej1_d;
  logic          ocupado_q, ocupado_d;
  logic          concluido_q, concluido_d;
  logic          vazio_q, vazio_d;

  logic          lib_rise, dev_rise, produto;
  logic [3:0]    montante;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    troco_d  = troco_q;
    tubo2_d  = tubo2_q;
    sel2_d   = sel2_q;
    produto  = 1'b0;
    montante = valor_moedas;
    lib_rise = liberar & ~lib_q;
    dev_rise = devolver & ~dev_q;

    case (state_q)
      OCIOSO: begin
        if (recarga) tubo2_d = TUBO2_INIT;
        // Refund wins over release; insufficient funds also degrade to a refund.
        if (!dev_rise && valor_moedas >= {1'b0, valor_produto}) begin
          produto  = 1'b1;
          montante = valor_moedas - {1'b0, valor_produto};
        end
        if (dev_rise || lib_rise) begin
          troco_d = montante;
          if (produto) begin
            state_d = MOTOR;
            cnt_d   = MOTOR_LOAD;
          end else if (montante != 4'd0) begin
            state_d = ESCOLHE;
          end else begin
            state_d = FIM;
          end
        end
      end
      MOTOR: begin
        if (cnt_q == '0) state_d = (troco_q != 4'd0) ? ESCOLHE : FIM;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ESCOLHE: begin
        if (troco_q >= 4'd2 && tubo2_q != 4'd0) begin
          sel2_d  = 1'b1;
          troco_d = troco_q - 4'd2;
          tubo2_d = tubo2_q - 4'd1;
        end else begin
          sel2_d  = 1'b0;
          troco_d = troco_q - 4'd1;
        end
        state_d = EJETA;
        cnt_d   = PULSE_LOAD;
      end
      EJETA: begin
        if (cnt_q == '0) begin
          state_d = PAUSA;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PAUSA: begin
        if (cnt_q == '0) state_d = (troco_q != 4'd0) ? ESCOLHE : FIM;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase

    // Outputs are decoded from the next state so they appear registered.
    motor_d     = (state_d == MOTOR);
    ej2_d       = (state_d == EJETA) && sel2_d;
    ej1_d       = (state_d == EJETA) && !sel2_d;
    ocupado_d   = (state_d != OCIOSO);
    concluido_d = (state_d == FIM);
    vazio_d     = (tubo2_d == 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= OCIOSO;
      cnt_q       <= '0;
      troco_q     <= 4'd0;
      tubo2_q     <= TUBO2_INIT;
      sel2_q      <= 1'b0;
      lib_q       <= 1'b0;
      dev_q       <= 1'b0;
      motor_q     <= 1'b0;
      ej2_q       <= 1'b0;
      ej1_q       <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      vazio_q     <= (TUBO2_INIT == 4'd0);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      troco_q     <= troco_d;
      tubo2_q     <= tubo2_d;
      sel2_q      <= sel2_d;
      lib_q       <= liberar;
      dev_q       <= devolver;
      motor_q     <= motor_d;
      ej2_q       <= ej2_d;
      ej1_q       <= ej1_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
      vazio_q     <= vazio_d;
    end
  end

  assign motor_produto  = motor_q;
  assign ejetor2        = ej2_q;
  assign ejetor1        = ej1_q;
  assign ocupado        = ocupado_q;
  assign concluido      = concluido_q;
  assign troco_restante = troco_q;
  assign tubo2_vazio    = vazio_q;

endmodule
